// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared opcodes, widths and entry types for the issue queue and dispatcher
package issue_queue_pkg;
    localparam logic [6:0] LOAD_OPCODE = 7'b0000011;
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam int IQ_DEPTH = 16;
    localparam int IQ_ADDR_WIDTH = 4;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] predict_pc;
    } iq_entry_t;
    typedef enum logic {TGT_RS, TGT_LSB} target_t;
endpackage

// File: rtl/issue_queue_classify.sv
// iq_target_classify: maps an instruction opcode to the reservation station or load/store buffer
module iq_target_classify
    import issue_queue_pkg::*;
(
    input  logic [31:0] inst,
    output target_t     target
);
    always_comb begin
        target = (inst[6:0] == LOAD_OPCODE || inst[6:0] == STORE_OPCODE) ? TGT_LSB : TGT_RS;
    end
endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order instruction FIFO issuing one head entry per cycle when downstream can accept
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int ADDR_WIDTH = IQ_ADDR_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  fet_valid_in,
    input  logic [31:0]           fet_inst_in,
    input  logic [31:0]           fet_pc_in,
    input  logic [31:0]           fet_predict_pc_in,
    output logic                  fet_full_out,
    input  logic                  rob_full_in,
    input  logic                  rs_full_in,
    input  logic                  lsb_full_in,
    input  logic                  rob_rollback_in,
    output logic                  dec_issue_out,
    output logic [31:0]           dec_inst_out,
    output logic [31:0]           dec_pc_out,
    output logic [31:0]           dec_predict_pc_out,
    output logic [ADDR_WIDTH:0]   count_out
);
    iq_entry_t mem [DEPTH];
    iq_entry_t head_entry;
    logic [ADDR_WIDTH-1:0] head, tail;
    logic [ADDR_WIDTH:0] count;
    logic empty, active, push, pop;
    target_t target;

    iq_target_classify u_classify (
        .inst   (head_entry.inst),
        .target (target)
    );

    assign empty = count == '0;
    assign active = rdy_in && !rst_in && !rob_rollback_in;
    assign fet_full_out = count == (ADDR_WIDTH+1)'(DEPTH);
    assign head_entry = empty ? iq_entry_t'{ZERO_WORD, ZERO_WORD, ZERO_WORD} : mem[head];
    assign push = active && fet_valid_in && !fet_full_out;
    assign pop = active && !empty && !rob_full_in && (target == TGT_LSB ? !lsb_full_in : !rs_full_in);
    assign dec_issue_out = pop;
    assign dec_inst_out = head_entry.inst;
    assign dec_pc_out = head_entry.pc;
    assign dec_predict_pc_out = head_entry.predict_pc;
    assign count_out = count;

    always_ff @(posedge clk_in) begin
        if (rst_in || rob_rollback_in) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
        end
    end

    // storage is deliberately left unreset; count gates every read
    always_ff @(posedge clk_in) begin
        if (push) mem[tail] <= iq_entry_t'{fet_inst_in, fet_pc_in, fet_predict_pc_in};
    end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: randomized and directed scoreboard bench for issue_queue
module tb_issue_queue;
    logic clk_in = 0;
    logic rst_in, rdy_in, fet_valid_in, rob_full_in, rs_full_in, lsb_full_in, rob_rollback_in;
    logic [31:0] fet_inst_in, fet_pc_in, fet_predict_pc_in;
    logic fet_full_out, dec_issue_out;
    logic [31:0] dec_inst_out, dec_pc_out, dec_predict_pc_out;
    logic [4:0] count_out;
    int checks = 0;
    int errors = 0;
    logic [95:0] ref_q [$];
    logic [31:0] pc_n = 0;

    always #5 clk_in = ~clk_in;

    issue_queue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .fet_valid_in(fet_valid_in), .fet_inst_in(fet_inst_in), .fet_pc_in(fet_pc_in),
        .fet_predict_pc_in(fet_predict_pc_in), .fet_full_out(fet_full_out),
        .rob_full_in(rob_full_in), .rs_full_in(rs_full_in), .lsb_full_in(lsb_full_in),
        .rob_rollback_in(rob_rollback_in), .dec_issue_out(dec_issue_out),
        .dec_inst_out(dec_inst_out), .dec_pc_out(dec_pc_out),
        .dec_predict_pc_out(dec_predict_pc_out), .count_out(count_out)
    );

    function automatic logic is_mem(input logic [31:0] inst);
        return inst[6:0] == 7'b0000011 || inst[6:0] == 7'b0100011;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // monitor: compares DUT against the queue model, then advances the model for the coming edge
    always @(negedge clk_in) begin
        logic exp_issue, exp_full;
        logic [95:0] exp_head;
        int n;
        n = ref_q.size();
        exp_head = n != 0 ? ref_q[0] : 96'h0;
        exp_full = n == 16;
        exp_issue = !rst_in && rdy_in && !rob_rollback_in && n != 0 && !rob_full_in &&
                    (is_mem(exp_head[95:64]) ? !lsb_full_in : !rs_full_in);
        chk("count", 96'(count_out), 96'(n));
        chk("full", 96'(fet_full_out), 96'(exp_full));
        chk("issue", 96'(dec_issue_out), 96'(exp_issue));
        chk("head", {dec_inst_out, dec_pc_out, dec_predict_pc_out}, exp_head);
        if (rst_in || rob_rollback_in) ref_q.delete();
        else if (rdy_in) begin
            if (exp_issue) void'(ref_q.pop_front());
            if (fet_valid_in && !exp_full)
                ref_q.push_back({fet_inst_in, fet_pc_in, fet_predict_pc_in});
        end
    end

    task automatic step(input logic v, input logic [6:0] op, input logic rf, input logic rsf,
                        input logic lf, input logic rb, input logic rdy, input logic rst);
        fet_valid_in = v;
        fet_inst_in = {$urandom_range(0, 32'h1ff_ffff) , op};
        fet_pc_in = pc_n;
        fet_predict_pc_in = pc_n + 4;
        rob_full_in = rf;
        rs_full_in = rsf;
        lsb_full_in = lf;
        rob_rollback_in = rb;
        rdy_in = rdy;
        rst_in = rst;
        @(posedge clk_in);
        #1;
        if (v) pc_n += 4;
    endtask

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 4))
            0: return 7'b0000011;
            1: return 7'b0100011;
            2: return 7'b0010011;
            3: return 7'b0110011;
            default: return 7'($urandom);
        endcase
    endfunction

    localparam logic [6:0] ADDI = 7'b0010011, ADD = 7'b0110011, LW = 7'b0000011;

    initial begin
        repeat (2) step(0, ADDI, 0, 0, 0, 0, 1, 1);
        repeat (3) step(1, ADDI, 0, 0, 0, 0, 1, 0);
        repeat (3) step(0, ADDI, 0, 0, 0, 0, 1, 0);
        repeat (17) step(1, ADDI, 1, 0, 0, 0, 1, 0);
        repeat (18) step(0, ADDI, 0, 0, 0, 0, 1, 0);
        step(1, LW, 0, 0, 1, 0, 1, 0);
        repeat (2) step(0, ADDI, 0, 0, 1, 0, 1, 0);
        step(0, ADDI, 0, 0, 0, 0, 1, 0);
        step(1, ADD, 0, 0, 1, 0, 1, 0);
        repeat (2) step(0, ADDI, 0, 0, 1, 0, 1, 0);
        repeat (5) step(1, ADDI, 1, 0, 0, 0, 1, 0);
        step(1, ADDI, 0, 0, 0, 1, 1, 0);
        repeat (2) step(0, ADDI, 0, 0, 0, 0, 1, 0);
        repeat (15) step(1, ADDI, 1, 0, 0, 0, 1, 0);
        step(1, ADDI, 0, 0, 0, 0, 1, 0);
        step(1, ADDI, 1, 0, 0, 0, 1, 0);
        repeat (2) step(1, ADDI, 0, 0, 0, 0, 1, 0);
        step(0, ADDI, 0, 0, 0, 1, 1, 0);
        repeat (3) step(1, ADDI, 1, 0, 0, 0, 1, 0);
        repeat (3) step(1, ADDI, 0, 0, 0, 0, 0, 0);
        repeat (5) step(0, ADDI, 0, 0, 0, 0, 1, 0);
        repeat (2) step(1, ADDI, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, rand_op(), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 299) == 0);
        @(negedge clk_in);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
# issue_queue

Instruction buffer and issue scheduler between the Fetcher and the Decoder. It holds fetched instructions with their PC and predicted PC in an in-order FIFO. Each cycle it presents at most one head entry to the Decoder, and only when the ReorderBuffer and the target unit (ReservationStation or LoadStoreBuffer) can accept it. On a ROB rollback it flushes every buffered instruction.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; must be a power of two and at least 2.
- `ADDR_WIDTH`, 4, log2(`DEPTH`).

Ports:
- `clk_in`  in  1  system clock; the only clock.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  global ready; when low the block holds all state.
- `fet_valid_in`  in  1  Fetcher offers an instruction this cycle.
- `fet_inst_in`  in  32  instruction word.
- `fet_pc_in`  in  32  instruction PC.
- `fet_predict_pc_in`  in  32  predicted next PC.
- `fet_full_out`  out  1  queue full; the Fetcher must not offer.
- `rob_full_in`  in  1  ROB cannot accept an entry this cycle.
- `rs_full_in`  in  1  ReservationStation cannot accept this cycle.
- `lsb_full_in`  in  1  LoadStoreBuffer cannot accept this cycle.
- `rob_rollback_in`  in  1  misprediction flush.
- `dec_issue_out`  out  1  head entry is issued to the Decoder this cycle.
- `dec_inst_out`  out  32  head instruction word.
- `dec_pc_out`  out  32  head PC.
- `dec_predict_pc_out`  out  32  head predicted PC.
- `count_out`  out  `ADDR_WIDTH`+1  current occupancy, 0..`DEPTH`.

## Operation
- Storage: a circular buffer with `head`, `tail` and `count` registers. Pointers are `ADDR_WIDTH` bits and wrap naturally at `DEPTH`.
- Push condition: `fet_valid_in && !fet_full_out && !rob_rollback_in && rdy_in`. On push, write the entry at `tail` and advance `tail`.
- `fet_full_out` = (`count` == `DEPTH`). It is computed from current state only, so a push is refused even if a pop happens in the same cycle.
- Target classification from head `inst[6:0]`:
  - `LOAD_OPCODE` (0000011) or `STORE_OPCODE` (0100011) target the LSB.
  - Every other opcode targets the RS.
- Issue (combinational): `dec_issue_out` = `rdy_in && !rst_in && !rob_rollback_in && count != 0 && !rob_full_in && (target_lsb ? !lsb_full_in : !rs_full_in)`.
- On issue, advance `head` at the clock edge.
- `dec_inst_out`, `dec_pc_out` and `dec_predict_pc_out` always show the head entry. When the queue is empty they are driven to `ZERO_WORD`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Rollback: at the edge where `rob_rollback_in` is high, `head`, `tail` and `count` all go to 0. The same-cycle push and issue are suppressed, so nothing reaches the Decoder that cycle.
- `rdy_in` low: no push, no issue, all registers hold. This has lower priority than reset.

## Timing
- Reset (at the edge with `rst_in` high) sets:
  - `head`, `tail`, `count` = 0.
  - `fet_full_out` = 0, `dec_issue_out` = 0, data outputs = 0, `count_out` = 0.
- Reset mid-operation discards every entry. No issue occurs in the reset cycle.
- Latency: an entry pushed at edge t can issue in cycle t+1 at the earliest (one-cycle buffer latency). There is no bypass.
- Throughput: one push and one issue per cycle.
- Downstream full inputs are sampled combinationally in the issue cycle. Their producers must already account for entries accepted in that cycle.
- The storage array is not reset; only the control registers are.
- Priority: `rst_in` > `rob_rollback_in` > `!rdy_in` > normal push/pop.

## Structure
- Opcode constants (`LOAD_OPCODE`, `STORE_OPCODE`), `WORD_RANGE` and `ZERO_WORD` come from the shared `header.v` defines.
- Add `IQ_DEPTH` and `IQ_ADDR_RANGE` there.
- One sub-module is natural: `iq_target_classify`, a combinational opcode-to-{RS, LSB} classifier. The Dispatcher can reuse it.

## Test plan
- Reset, then push 3 ADDI instructions (PCs 0x0, 0x4, 0x8) on back-to-back cycles with all full inputs low -> issues at cycles 1, 2 and 3 in PC order, and `count_out` returns to 0.
- Fill 16 entries with `rob_full_in`=1 -> `fet_full_out`=1 and `count_out`=16. A 17th push is refused. After releasing `rob_full_in`, one issue per cycle and the pointer wraps correctly.
- Head is LW (opcode 0000011) with `lsb_full_in`=1 and `rs_full_in`=0 -> no issue. Head is ADD with `lsb_full_in`=1 -> issues.
- Queue holds 5 entries and `rob_rollback_in` pulses with a concurrent `fet_valid_in` -> `dec_issue_out`=0 that cycle, `count_out`=0 next cycle, and the concurrent instruction is dropped.
- With `count` at 15, push and issue in the same cycle -> `count_out` stays 15. With `count` at 16, `fet_full_out` stays 1 during the pop.
- `rdy_in`=0 for 3 cycles with pending entries and `fet_valid_in`=1 -> no state change. After `rdy_in` returns high, issue resumes from the same head PC.
